// File: rtl/spi_buf_sched.sv
// spi_buf_sched: round-robin scheduler between the transfer buffer
// SPI-side port and the SPI master, in the divided-clock domain.
module spi_buf_sched #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int DW      = 41,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  output logic [AW-1:0] buf_addr,
  output logic          buf_rd,
  input  logic [DW-1:0] buf_rdata,
  output logic          buf_we,
  output logic [DW-1:0] buf_wdata,
  output logic          spi_start,
  output logic [7:0]    spi_cmd,
  output logic [31:0]   spi_wdata,
  input  logic          spi_done,
  input  logic [31:0]   spi_rdata,
  output logic          busy,
  output logic [AW-1:0] cur_idx,
  output logic          err,
  output logic [15:0]   done_cnt
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, RD, CHK, START, WAIT, WB
  } state_t;

  state_t        state;
  logic [AW-1:0] ptr;
  logic [TW-1:0] timer;

  assign buf_addr = ptr;
  assign cur_idx  = ptr;

  // timer counts cycles since spi_start, so the abort lands TIMEOUT cycles later
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      ptr       <= '0;
      timer     <= '0;
      buf_rd    <= 1'b0;
      buf_we    <= 1'b0;
      buf_wdata <= '0;
      spi_start <= 1'b0;
      spi_cmd   <= '0;
      spi_wdata <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      done_cnt  <= '0;
    end else begin
      buf_rd    <= 1'b0;
      buf_we    <= 1'b0;
      spi_start <= 1'b0;
      err       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en) begin
            state  <= RD;
            buf_rd <= 1'b1;
          end
        end
        RD: state <= CHK;
        CHK: begin
          if (buf_rdata[DW-1]) begin
            spi_cmd   <= buf_rdata[DW-2 -: 8];
            spi_wdata <= buf_rdata[31:0];
            spi_start <= 1'b1;
            busy      <= 1'b1;
            timer     <= '0;
            state     <= START;
          end else begin
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
            if (en) begin
              state  <= RD;
              buf_rd <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        START: begin
          timer <= timer + 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          if (spi_done) begin
            buf_we    <= 1'b1;
            buf_wdata <= {1'b0, spi_cmd, spi_rdata};
            done_cnt  <= done_cnt + 1'b1;
            state     <= WB;
          end else if (timer == TLAST) begin
            err       <= 1'b1;
            buf_we    <= 1'b1;
            buf_wdata <= {1'b0, spi_cmd, 32'hFFFF_FFFF};
            state     <= WB;
          end
        end
        WB: begin
          busy <= 1'b0;
          ptr  <= (ptr == LAST) ? '0 : ptr + 1'b1;
          if (en) begin
            state  <= RD;
            buf_rd <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_buf_sched.md
Name: spi_buf_sched

Overview:
- Transfer scheduler between the 16-entry dual-port transfer buffer (SPI-side port) and the SPI master.
- Round-robin scans buffer entries for pending commands posted by the Wishbone side.
- Hands each pending command to the SPI master, then writes the SPI result back into the same entry with the pending bit cleared.
- Sits in the divided-clock domain, replacing direct buffer/SPI coupling.

Parameters:
- DEPTH, 16, number of buffer entries (power of two).
- AW, 4, buffer address width, log2(DEPTH).
- DW, 41, buffer word width. Layout: [40] PEND, [39:32] CMD, [31:0] DATA.
- TIMEOUT, 1024, max cycles to wait for spi_done before aborting an entry.

Ports:
- clk  in  1  divided SPI-domain clock.
- rstn  in  1  reset. Asynchronous assert, active-low.
- en  in  1  scheduler enable.
- buf_addr  out  AW  buffer port-B address.
- buf_rd  out  1  buffer read strobe.
- buf_rdata  in  DW  buffer read data. Valid the cycle after buf_rd.
- buf_we  out  1  buffer write strobe.
- buf_wdata  out  DW  buffer write data.
- spi_start  out  1  one-cycle start pulse to the SPI master.
- spi_cmd  out  8  command byte. Held from spi_start until done or abort.
- spi_wdata  out  32  transmit data. Held with spi_cmd.
- spi_done  in  1  one-cycle transfer-complete pulse.
- spi_rdata  in  32  receive data. Valid when spi_done=1.
- busy  out  1  high in START/WAIT/WB.
- cur_idx  out  AW  entry currently scanned or served.
- err  out  1  one-cycle pulse on timeout abort.
- done_cnt  out  16  count of completed entries. Wraps at 65535→0.

Behaviour:
- Reset (rstn=0, async): state=IDLE, ptr=0, timer=0, done_cnt=0. All outputs 0, including buf_addr=0 and spi_cmd/spi_wdata=0.
- States: IDLE, RD, CHK, START, WAIT, WB.
- IDLE: en=1 → RD next cycle.
- RD: buf_addr=ptr, buf_rd=1 → CHK.
- CHK: sample buf_rdata.
  - PEND=1: latch CMD/DATA into spi_cmd/spi_wdata → START.
  - PEND=0: ptr=ptr+1 (DEPTH-1 wraps to 0); next state is RD if en=1, else IDLE.
  - Empty-entry scan cost: 2 cycles per entry.
- START: spi_start=1 for exactly one cycle, timer=0 → WAIT.
- WAIT: timer increments every cycle.
  - spi_done=1: latch spi_rdata → WB.
  - timer reaches TIMEOUT-1 without spi_done: err=1 for one cycle, write-back DATA=32'hFFFF_FFFF → WB.
- WB: buf_we=1, buf_addr=ptr, buf_wdata={1'b0, CMD, result}.
  - done_cnt increments on success only, not on abort.
  - ptr=ptr+1 with wrap; next state is RD if en=1, else IDLE.
- spi_done outside WAIT is ignored.
- en deasserted during START/WAIT/WB: current entry completes and is written back, then IDLE. en is only sampled in IDLE, CHK and WB.
- buf_rd and buf_we are never high in the same cycle. The block issues at most one read or write per cycle.
- A Wishbone write to an entry while it is in WAIT is overwritten by WB. Software must not touch entries with PEND=1.
- ptr is not reset by en toggling; scanning resumes where it stopped.
- Reset mid-WAIT: SPI master is abandoned and the entry keeps PEND=1. After reset it is re-served from index 0 onward.
- cur_idx = ptr at all times.

Test Plan:
- Single entry: buffer[3]={1,8'h03,32'h0000_0010}, en=1, spi_done 20 cycles after spi_start with spi_rdata=32'hA5A5_0001 → spi_start once with spi_cmd=8'h03, spi_wdata=32'h10; buffer[3]={0,8'h03,32'hA5A5_0001}; done_cnt=1.
- Empty sweep: all PEND=0, en=1 for 40 cycles → buf_rd at ptr 0..15 then wrap to 0, period 2 cycles; no spi_start, no buf_we.
- Round robin: entries 15 and 0 pending → served in order 15 then 0 across the wrap; done_cnt=2.
- Timeout: entry 5 pending, spi_done never asserted, TIMEOUT=16 → err pulse 16 cycles after START; buffer[5] DATA=32'hFFFF_FFFF, PEND=0; done_cnt unchanged.
- en drop mid-WAIT: en→0, then spi_done → WB completes; state IDLE; no further buf_rd until en=1, then resume at ptr+1.
- Async reset in WAIT: rstn=0 mid-cycle → outputs 0 immediately, no buf_we; after release, the entry is still pending and gets served.
